// File: rtl/i2c_package.sv
// i2c_package: types and constants shared by the I2C target controller.
//   i2c_slv_state_e   - target controller FSM states
//   I2C_BITS_PER_BYTE - data bits per byte on the bus
//   I2C_RW_READ       - value of the R/W address bit that selects a read
package i2c_package;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK, WAIT_STOP
  } i2c_slv_state_e;

  localparam int   I2C_BITS_PER_BYTE = 8;
  localparam logic I2C_RW_READ       = 1'b1;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizes the asynchronous SCL/SDA pad inputs and derives
// the bus events the target FSM acts on.
//   clk_i, rst_i      - system clock, synchronous active-high reset
//   scl_i, sda_i      - raw pad inputs
//   sda_o             - synchronized SDA level
//   scl_rise_o/fall_o - one-cycle pulses on synchronized SCL edges
//   start_o / stop_o  - one-cycle pulses on START / STOP conditions
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // Reset to the released (high) bus level so no false edge is seen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  // SCL must be high on both samples so an SCL edge is never taken as an event.
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
endmodule

// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl: I2C target controller on shared open-drain pads.
//   wb_clk_i, wb_rst_i, enable   - clock, sync active-high reset, core enable
//   my_addr                      - own 7-bit address
//   scl/sda_pad_i/_o/_padoen_o   - pads; pad_o is 0, padoen_o=0 pulls low
//   rx_data/rx_valid/rx_ready    - bytes written by the master to the host
//   tx_req/tx_data/tx_valid      - bytes fetched from the host for reads
//   busy, addressed, rw          - bus / selection status
//   stop_det, nack_rcvd          - one-cycle event pulses
module i2c_slave_ctrl
  import i2c_package::*;
#(
  parameter int HOLD_CYC    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       enable,
  input  logic [6:0] my_addr,
  input  logic       scl_pad_i,
  output logic       scl_pad_o,
  output logic       scl_padoen_o,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       busy,
  output logic       addressed,
  output logic       rw,
  output logic       stop_det,
  output logic       nack_rcvd
);
  localparam logic [3:0] BIT_LAST = 4'(I2C_BITS_PER_BYTE - 1);
  localparam logic [3:0] BIT_ACK0 = 4'(I2C_BITS_PER_BYTE);      // after 8th rise
  localparam logic [3:0] BIT_ACK1 = 4'(I2C_BITS_PER_BYTE + 1);  // ACK being driven
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC);

  i2c_slv_state_e state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d, tx_byte_q, tx_byte_d, rx_data_q, rx_data_d;
  logic [7:0] hold_q, hold_d;
  logic       tx_loaded_q, tx_loaded_d, rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
  logic       addressed_q, addressed_d, rw_q, rw_d, busy_q, busy_d;
  logic       sda_drv_q, sda_drv_d, scl_str_q, scl_str_d;
  logic       stop_det_q, stop_det_d, nack_q, nack_d;
  logic       sda_s, scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0] byte_in;
  logic       hold_fire, tx_hs;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .scl_i(scl_pad_i), .sda_i(sda_pad_i),
    .sda_o(sda_s), .scl_rise_o(scl_rise), .scl_fall_o(scl_fall),
    .start_o(start_ev), .stop_o(stop_ev)
  );

  always_comb begin
    state_d = state_q;  bitcnt_d = bitcnt_q;  shift_d = shift_q;
    tx_byte_d = tx_byte_q;  tx_loaded_d = tx_loaded_q;  rx_data_d = rx_data_q;
    rx_valid_d = rx_valid_q;  tx_req_d = tx_req_q;  addressed_d = addressed_q;
    rw_d = rw_q;  busy_d = busy_q;  sda_drv_d = sda_drv_q;  scl_str_d = scl_str_q;
    hold_d = hold_q;  stop_det_d = 1'b0;  nack_d = 1'b0;
    byte_in   = {shift_q[6:0], sda_s};
    hold_fire = (hold_q == 8'd1);
    tx_hs     = tx_req_q & tx_valid;

    // Host handshakes complete regardless of bus state.
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (tx_hs) begin
      tx_req_d    = 1'b0;
      tx_byte_d   = tx_data;
      tx_loaded_d = 1'b1;
    end

    // Hold timer: SDA may only change when it expires (hold_q==1), counted
    // from the last SCL fall or from the moment a read byte is latched.
    if (tx_hs || scl_fall)  hold_d = HOLD_LD;
    else if (hold_q != 8'd0) hold_d = hold_q - 8'd1;

    if (stop_ev) begin
      state_d = IDLE;  bitcnt_d = '0;  hold_d = '0;
      sda_drv_d = 1'b0;  scl_str_d = 1'b0;  busy_d = 1'b0;
      stop_det_d = addressed_q;  addressed_d = 1'b0;
      rx_valid_d = 1'b0;  tx_req_d = 1'b0;
    end else if (start_ev) begin
      state_d = ADDR;  bitcnt_d = '0;  hold_d = '0;
      sda_drv_d = 1'b0;  scl_str_d = 1'b0;  busy_d = 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d  = byte_in;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == BIT_LAST) begin
              if (byte_in[7:1] == my_addr) begin
                addressed_d = 1'b1;
                rw_d        = byte_in[0];
                state_d     = ADDR_ACK;
              end else begin
                addressed_d = 1'b0;
                state_d     = WAIT_STOP;
              end
            end
          end
        end
        ADDR_ACK, WR_ACK: begin
          if (scl_fall && bitcnt_q == BIT_ACK0) begin
            bitcnt_d = BIT_ACK1;
          end else if (scl_fall) begin
            bitcnt_d = '0;
            if (state_q == WR_ACK || rw_q != I2C_RW_READ) begin
              state_d = WR_DATA;
            end else begin
              state_d     = RD_LOAD;
              scl_str_d   = 1'b1;
              tx_req_d    = 1'b1;
              tx_loaded_d = 1'b0;
            end
          end
          if (bitcnt_q == BIT_ACK1 && hold_fire) sda_drv_d = 1'b1;
          // Keep SCL low through the ACK low phase until the host takes the byte.
          if (state_q == WR_ACK && (bitcnt_d == BIT_ACK1)) scl_str_d = rx_valid_d;
        end
        WR_DATA: begin
          if (hold_fire) sda_drv_d = 1'b0;
          if (scl_rise) begin
            shift_d  = byte_in;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == BIT_LAST) begin
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
              state_d    = WR_ACK;
            end
          end
        end
        RD_LOAD: begin
          if (tx_loaded_q && hold_fire) begin
            sda_drv_d = ~tx_byte_q[7];
            scl_str_d = 1'b0;
            bitcnt_d  = '0;
            state_d   = RD_DATA;
          end
        end
        RD_DATA: begin
          if (hold_fire) sda_drv_d = ~tx_byte_q[7];
          if (scl_rise && !sda_drv_q && !sda_s) begin
            // Someone else holds SDA low while we send a 1: back off.
            sda_drv_d = 1'b0;
            state_d   = WAIT_STOP;
          end else if (scl_fall) begin
            if (bitcnt_q == BIT_LAST) begin
              state_d = RD_ACK;
            end else begin
              bitcnt_d  = bitcnt_q + 4'd1;
              tx_byte_d = {tx_byte_q[6:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          if (hold_fire) sda_drv_d = 1'b0;
          if (scl_rise && sda_s) begin
            nack_d  = 1'b1;
            state_d = WAIT_STOP;
          end else if (scl_fall) begin
            state_d     = RD_LOAD;
            scl_str_d   = 1'b1;
            tx_req_d    = 1'b1;
            tx_loaded_d = 1'b0;
          end
        end
        WAIT_STOP: begin
          sda_drv_d = 1'b0;
          scl_str_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !enable) begin
      state_q <= IDLE;  bitcnt_q <= '0;  shift_q <= '0;  tx_byte_q <= '0;
      tx_loaded_q <= 1'b0;  rx_data_q <= '0;  rx_valid_q <= 1'b0;
      tx_req_q <= 1'b0;  addressed_q <= 1'b0;  rw_q <= 1'b0;  busy_q <= 1'b0;
      sda_drv_q <= 1'b0;  scl_str_q <= 1'b0;  hold_q <= '0;
      stop_det_q <= 1'b0;  nack_q <= 1'b0;
    end else begin
      state_q <= state_d;  bitcnt_q <= bitcnt_d;  shift_q <= shift_d;
      tx_byte_q <= tx_byte_d;  tx_loaded_q <= tx_loaded_d;  rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;  tx_req_q <= tx_req_d;  addressed_q <= addressed_d;
      rw_q <= rw_d;  busy_q <= busy_d;  sda_drv_q <= sda_drv_d;
      scl_str_q <= scl_str_d;  hold_q <= hold_d;
      stop_det_q <= stop_det_d;  nack_q <= nack_d;
    end
  end

  // Pads release immediately when the core is disabled.
  assign scl_pad_o    = 1'b0;
  assign sda_pad_o    = 1'b0;
  assign scl_padoen_o = ~(scl_str_q & enable);
  assign sda_padoen_o = ~(sda_drv_q & enable);
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign tx_req       = tx_req_q;
  assign busy         = busy_q;
  assign addressed    = addressed_q;
  assign rw           = rw_q;
  assign stop_det     = stop_det_q;
  assign nack_rcvd    = nack_q;
endmodule
